change_update_scheduler: RTL and testbench

//  Collects update pulses from N change-detect channels (48-bit data + 1-cycle update strobe each).

---
 rtl/change_update_scheduler_pkg.sv | 18 +
 rtl/change_update_scheduler_if.sv | 29 ++
 rtl/change_update_scheduler_rr_select.sv | 30 +++
 rtl/change_update_scheduler.sv | 106 ++++++++++
 tb/tb_change_update_scheduler.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/change_update_scheduler_pkg.sv
// Shared constants, index-width helper and output-port state encoding.
package change_update_scheduler_pkg;

   localparam int unsigned DW_DEFAULT  = 48;
   localparam int unsigned NCH_DEFAULT = 4;

   // Index width for n entries, never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned n);
      if (n <= 2) return 1;
      return 32'($clog2(n));
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } out_state_e;

endpackage

// File: rtl/change_update_scheduler_if.sv
// Channel update inputs plus the shared valid/ready write port.
interface change_update_scheduler_if
   import change_update_scheduler_pkg::*;
#(
   parameter int unsigned NCH = NCH_DEFAULT,
   parameter int unsigned DW  = DW_DEFAULT
);
   localparam int unsigned CW = idx_width(NCH);

   logic [NCH-1:0]    upd_in;
   logic [NCH*DW-1:0] data_in;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [CW-1:0]     out_chan;
   logic [NCH-1:0]    overwrite;
   logic              overwrite_clr;

   modport master (
      output upd_in, data_in, out_ready, overwrite_clr,
      input  out_valid, out_data, out_chan, overwrite
   );

   modport slave (
      input  upd_in, data_in, out_ready, overwrite_clr,
      output out_valid, out_data, out_chan, overwrite
   );

endinterface

// File: rtl/change_update_scheduler_rr_select.sv
// Round-robin first-set finder: searches ptr+1, ptr+2 ... modulo NCH.
module rr_select
   import change_update_scheduler_pkg::*;
#(
   parameter  int unsigned NCH = NCH_DEFAULT,
   localparam int unsigned CW  = idx_width(NCH)
)(
   input  logic [NCH-1:0] i_req,
   input  logic [CW-1:0]  i_ptr,
   output logic [CW-1:0]  o_gnt_idx_c,
   output logic           o_gnt_any_c
);

   int unsigned w_idx;

   // First requester after the pointer wins
   always_comb begin
      o_gnt_idx_c = '0;
      o_gnt_any_c = 1'b0;
      w_idx       = 0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         w_idx = (32'(i_ptr) + k) % NCH;
         if (!o_gnt_any_c && i_req[CW'(w_idx)]) begin
            o_gnt_any_c = 1'b1;
            o_gnt_idx_c = CW'(w_idx);
         end
      end
   end

endmodule

// File: rtl/change_update_scheduler.sv
// Coalesces per-channel updates and serialises them round-robin onto one write port.
module change_update_scheduler
   import change_update_scheduler_pkg::*;
#(
   parameter int unsigned NCH = NCH_DEFAULT,
   parameter int unsigned DW  = DW_DEFAULT
)(
   input  logic                     clk,
   input  logic                     rst_n,
   change_update_scheduler_if.slave bus
);

   localparam int unsigned CW = idx_width(NCH);

   out_state_e     r_state;
   out_state_e     w_state_nxt;
   logic           w_grant;
   logic           w_gnt_any;
   logic [CW-1:0]  w_gnt_idx;
   logic [NCH-1:0] w_gnt_onehot;
   logic [NCH-1:0] r_pending;
   logic [NCH-1:0] w_pending_nxt;
   logic [NCH-1:0] r_overwrite;
   logic [NCH-1:0] w_overwrite_nxt;
   logic [DW-1:0]  r_shadow [NCH];
   logic [CW-1:0]  r_rr_ptr;
   logic [CW-1:0]  r_out_chan;
   logic [DW-1:0]  r_out_data;

   rr_select #(.NCH(NCH)) u_rr_select (
      .i_req       (r_pending),
      .i_ptr       (r_rr_ptr),
      .o_gnt_idx_c (w_gnt_idx),
      .o_gnt_any_c (w_gnt_any)
   );

   // Output-port state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Grant decision: from IDLE on any pending, from HOLD only once the current word is taken
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_any) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               if (w_gnt_any) w_grant     = 1'b1;
               else           w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Pending/overwrite next state: a fresh update beats the grant clear, and a granted channel never flags
   always_comb begin
      w_gnt_onehot = '0;
      if (w_grant) w_gnt_onehot[w_gnt_idx] = 1'b1;
      w_pending_nxt   = bus.upd_in | (r_pending & ~w_gnt_onehot);
      w_overwrite_nxt = (bus.overwrite_clr ? '0 : r_overwrite)
                      | (bus.upd_in & r_pending & ~w_gnt_onehot);
   end

   // Shadow capture, pending and sticky overwrite flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending   <= '0;
         r_overwrite <= '0;
         for (int i = 0; i < NCH; i++) r_shadow[i] <= '0;
      end else begin
         r_pending   <= w_pending_nxt;
         r_overwrite <= w_overwrite_nxt;
         for (int i = 0; i < NCH; i++) begin
            if (bus.upd_in[i]) r_shadow[i] <= bus.data_in[i*DW +: DW];
         end
      end
   end

   // Output word and round-robin pointer load on each grant (old shadow value is sent)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_data <= '0;
         r_out_chan <= '0;
         r_rr_ptr   <= CW'(NCH - 1);
      end else if (w_grant) begin
         r_out_data <= r_shadow[w_gnt_idx];
         r_out_chan <= w_gnt_idx;
         r_rr_ptr   <= w_gnt_idx;
      end
   end

   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.out_data  = r_out_data;
   assign bus.out_chan  = r_out_chan;
   assign bus.overwrite = r_overwrite;

endmodule

// File: tb/tb_change_update_scheduler.sv
// Directed and random stimulus for change_update_scheduler with a transfer scoreboard.
module tb_change_update_scheduler;
   import change_update_scheduler_pkg::*;

   localparam int unsigned NCH = 4;
   localparam int unsigned DW  = 48;
   localparam int unsigned CW  = idx_width(NCH);

   typedef struct packed {
      logic [CW-1:0] chan;
      logic [DW-1:0] data;
   } xfer_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   change_update_scheduler_if #(.NCH(NCH), .DW(DW)) ifc ();

   change_update_scheduler #(.NCH(NCH), .DW(DW)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int errors = 0;
   int checks = 0;
   xfer_t exp_q[$];
   bit sb_en   = 1'b0;
   bit soak_en = 1'b0;

   // soak tracking
   bit [NCH-1:0]  sk_pend;
   bit [NCH-1:0]  prev_upd;
   bit            prev_valid;
   bit            prev_xfer;
   int            sk_wait [NCH];
   logic [DW-1:0] last_wr  [NCH];
   logic [DW-1:0] last_del [NCH];
   bit [NCH-1:0]  wr_seen;
   int            mon_g;
   xfer_t         sb_e;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge; strobes are single-cycle
   task automatic step();
      @(posedge clk);
      #1;
      ifc.upd_in        = '0;
      ifc.overwrite_clr = 1'b0;
   endtask

   task automatic set_ch(input int i, input logic [DW-1:0] d);
      ifc.upd_in[i]            = 1'b1;
      ifc.data_in[i*DW +: DW]  = d;
   endtask

   task automatic push(input int c, input logic [DW-1:0] d);
      xfer_t e;
      e.chan = CW'(c);
      e.data = d;
      exp_q.push_back(e);
   endtask

   // scoreboard: every accepted word must match the next expected one
   always @(negedge clk) begin
      if (sb_en && rst_n === 1'b1 && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
         chk("sb_expected_available", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            chk("sb_chan", 64'(ifc.out_chan), 64'(sb_e.chan));
            chk("sb_data", 64'(ifc.out_data), 64'(sb_e.data));
         end
      end
   end

   // soak monitor: grants only of pending channels, bounded wait, latest value delivered
   always @(negedge clk) begin
      if (soak_en) begin
         if (ifc.out_valid === 1'b1 && (!prev_valid || prev_xfer)) begin
            mon_g = int'(ifc.out_chan);
            chk("soak_grant_was_pending", 64'(sk_pend[mon_g]), 64'(1));
            chk("soak_fair_wait", 64'(sk_wait[mon_g] <= NCH - 1), 64'(1));
            sk_pend[mon_g] = 1'b0;
            sk_wait[mon_g] = 0;
            for (int j = 0; j < NCH; j++) begin
               if (sk_pend[j]) sk_wait[j]++;
            end
         end
         sk_pend = sk_pend | prev_upd;
         if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) last_del[ifc.out_chan] = ifc.out_data;
         prev_valid = (ifc.out_valid === 1'b1);
         prev_xfer  = (ifc.out_valid === 1'b1) && (ifc.out_ready === 1'b1);
         prev_upd   = ifc.upd_in;
      end
   end

   initial begin
      logic [DW-1:0] d;
      rst_n             = 1'b0;
      ifc.upd_in        = '0;
      ifc.data_in       = '0;
      ifc.out_ready     = 1'b1;
      ifc.overwrite_clr = 1'b0;

      // reset state
      #12;
      chk("rst_valid", 64'(ifc.out_valid), 64'(0));
      chk("rst_chan",  64'(ifc.out_chan),  64'(0));
      chk("rst_data",  64'(ifc.out_data),  64'(0));
      chk("rst_ovw",   64'(ifc.overwrite), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      sb_en = 1'b1;

      // single update on channel 2, two-cycle latency, one transfer
      step();
      set_ch(2, 48'h0000_1234_5678);
      push(2, 48'h0000_1234_5678);
      @(negedge clk); chk("single_t0_valid", 64'(ifc.out_valid), 64'(0));
      step(); @(negedge clk); chk("single_t1_valid", 64'(ifc.out_valid), 64'(0));
      step(); @(negedge clk);
      chk("single_t2_valid", 64'(ifc.out_valid), 64'(1));
      chk("single_t2_chan",  64'(ifc.out_chan),  64'(2));
      chk("single_t2_data",  64'(ifc.out_data),  64'h0000_1234_5678);
      step(); @(negedge clk); chk("single_t3_valid", 64'(ifc.out_valid), 64'(0));
      repeat (3) step();
      chk("single_q_empty", 64'(exp_q.size()), 64'(0));

      // reset in HOLD drops valid at once and discards pending work
      sb_en = 1'b0;
      ifc.out_ready = 1'b0;
      step();
      set_ch(2, 48'h0000_0000_AAAA);
      set_ch(0, 48'h0000_0000_BBBB);
      step(); step();
      @(negedge clk);
      chk("rstmid_hold_valid", 64'(ifc.out_valid), 64'(1));
      chk("rstmid_hold_chan",  64'(ifc.out_chan),  64'(0));
      #1 rst_n = 1'b0;
      #1;
      chk("rstmid_async_valid", 64'(ifc.out_valid), 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ifc.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(); @(negedge clk);
         chk("rstmid_no_output", 64'(ifc.out_valid), 64'(0));
      end
      exp_q.delete();
      sb_en = 1'b1;

      // all four at once from reset pointer: 0,1,2,3 back to back
      step();
      for (int i = 0; i < NCH; i++) begin
         d = 48'hA0A0_0000_0000 | DW'(i);
         set_ch(i, d);
         push(i, d);
      end
      step();
      for (int k = 0; k < NCH; k++) begin
         step(); @(negedge clk);
         chk("all4_b2b_valid", 64'(ifc.out_valid), 64'(1));
      end
      step(); @(negedge clk);
      chk("all4_end_valid", 64'(ifc.out_valid), 64'(0));
      chk("all4_q_empty", 64'(exp_q.size()), 64'(0));

      // pointer parked on 1, then all four: 2,3,0,1
      step();
      set_ch(1, 48'h0000_0000_1111);
      push(1, 48'h0000_0000_1111);
      step(); step();
      for (int i = 0; i < NCH; i++) begin
         d = 48'hB0B0_0000_0000 | DW'(i);
         set_ch(i, d);
      end
      push(2, 48'hB0B0_0000_0002);
      push(3, 48'hB0B0_0000_0003);
      push(0, 48'hB0B0_0000_0000);
      push(1, 48'hB0B0_0000_0001);
      step();
      for (int k = 0; k < NCH; k++) begin
         step(); @(negedge clk);
         chk("rot_b2b_valid", 64'(ifc.out_valid), 64'(1));
      end
      step(); @(negedge clk);
      chk("rot_end_valid", 64'(ifc.out_valid), 64'(0));
      chk("rot_q_empty", 64'(exp_q.size()), 64'(0));

      // backpressure: HOLD stable for 10 cycles while channel 3 is coalesced
      ifc.out_ready = 1'b0;
      step();
      set_ch(1, 48'h0000_4141_4141);
      push(1, 48'h0000_4141_4141);
      step(); step();
      for (int k = 0; k < 10; k++) begin
         if (k > 0) step();
         if (k == 0) set_ch(3, 48'h0000_0000_000A);
         if (k == 2) set_ch(3, 48'h0000_0000_000B);
         @(negedge clk);
         chk("bp_valid", 64'(ifc.out_valid), 64'(1));
         chk("bp_chan",  64'(ifc.out_chan),  64'(1));
         chk("bp_data",  64'(ifc.out_data),  64'h0000_4141_4141);
      end
      push(3, 48'h0000_0000_000B);
      step();
      ifc.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ovw_set", 64'(ifc.overwrite), 64'(4'b1000));
      repeat (4) step();
      @(negedge clk);
      chk("bp_ovw_sticky", 64'(ifc.overwrite), 64'(4'b1000));
      chk("bp_q_empty", 64'(exp_q.size()), 64'(0));
      step();
      ifc.overwrite_clr = 1'b1;
      step(); @(negedge clk);
      chk("bp_ovw_cleared", 64'(ifc.overwrite), 64'(0));

      // collision: update arrives on the grant edge of the same channel
      step();
      set_ch(0, 48'h0000_0000_C0C0);
      push(0, 48'h0000_0000_C0C0);
      step();
      set_ch(0, 48'h0000_0000_C1C1);
      push(0, 48'h0000_0000_C1C1);
      step(); @(negedge clk);
      chk("coll_old_valid", 64'(ifc.out_valid), 64'(1));
      chk("coll_old_data",  64'(ifc.out_data),  64'h0000_0000_C0C0);
      step(); @(negedge clk);
      chk("coll_new_valid", 64'(ifc.out_valid), 64'(1));
      chk("coll_new_data",  64'(ifc.out_data),  64'h0000_0000_C1C1);
      step(); @(negedge clk);
      chk("coll_end_valid", 64'(ifc.out_valid), 64'(0));
      chk("coll_no_ovw",    64'(ifc.overwrite), 64'(0));
      chk("coll_q_empty",   64'(exp_q.size()), 64'(0));

      // random soak with fairness and last-value checks
      sb_en      = 1'b0;
      sk_pend    = '0;
      prev_upd   = '0;
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
      wr_seen    = '0;
      for (int i = 0; i < NCH; i++) begin
         sk_wait[i]  = 0;
         last_wr[i]  = '0;
         last_del[i] = '0;
      end
      soak_en = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               d = DW'({$urandom(), $urandom()});
               set_ch(i, d);
               last_wr[i] = d;
               wr_seen[i] = 1'b1;
            end
         end
         ifc.out_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      ifc.out_ready = 1'b1;
      repeat (20) step();
      @(negedge clk);
      soak_en = 1'b0;
      chk("soak_drained_valid", 64'(ifc.out_valid), 64'(0));
      chk("soak_none_pending",  64'(sk_pend), 64'(0));
      for (int i = 0; i < NCH; i++) begin
         if (wr_seen[i]) chk($sformatf("soak_last_value_ch%0d", i), 64'(last_del[i]), 64'(last_wr[i]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
